// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes.
// Register map on Addr[3:2]: 0 CTRL, 1 PRESET, 2 COUNT (read-only), 3 reads zero.
module timer_counter #(
  parameter logic [31:0] PRESET_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  state_t      state_q;
  logic        enable_q;
  logic [1:0]  mode_q;
  logic        im_q;
  logic [31:0] preset_q;
  logic [31:0] count_q;
  logic        irqPending_q;

  logic ctrlWr;
  logic presetWr;
  logic unusedAddrBits;

  assign ctrlWr         = WE && (Addr[3:2] == REG_CTRL);
  assign presetWr       = WE && (Addr[3:2] == REG_PRESET);
  assign unusedAddrBits = ^{Addr[31:4], Addr[1:0]};

  // CPU writes come after the FSM case so they override FSM updates in the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      enable_q     <= 1'b0;
      mode_q       <= 2'd0;
      im_q         <= 1'b0;
      preset_q     <= PRESET_RESET;
      count_q      <= 32'd0;
      irqPending_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable_q) state_q <= S_LOAD;
        end
        S_LOAD: begin
          count_q <= preset_q;
          state_q <= S_CNT;
        end
        S_CNT: begin
          if (!enable_q) begin
            state_q <= S_IDLE;
          end else if (count_q > 32'd1) begin
            count_q <= count_q - 32'd1;
          end else begin
            count_q      <= 32'd0;
            irqPending_q <= 1'b1;
            state_q      <= S_INT;
          end
        end
        S_INT: begin
          if (mode_q == 2'd1) begin
            irqPending_q <= 1'b0;
            state_q      <= S_LOAD;
          end else begin
            enable_q <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (ctrlWr) begin
        enable_q <= DataIn[0];
        mode_q   <= DataIn[2:1];
        im_q     <= DataIn[3];
      end
      if (presetWr) preset_q <= DataIn;
      if (ctrlWr || presetWr) irqPending_q <= 1'b0;
    end
  end

  always_comb begin
    DataOut = 32'd0;
    case (Addr[3:2])
      REG_CTRL:   DataOut = {28'd0, im_q, mode_q, enable_q};
      REG_PRESET: DataOut = preset_q;
      REG_COUNT:  DataOut = count_q;
      default:    DataOut = 32'd0;
    endcase
  end

  assign IRQ = im_q & irqPending_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: expected reads are queued with their tag,
// then popped and compared against DataOut/IRQ half a cycle after each edge.
module tb_timer_counter;

  localparam logic [1:0] CTRL   = 2'd0;
  localparam logic [1:0] PRESET = 2'd1;
  localparam logic [1:0] COUNT  = 2'd2;
  localparam logic [1:0] R3     = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        IRQ;

  int errors = 0;
  int checks = 0;

  string       tagQ[$];
  logic [31:0] dataQ[$];
  logic        irqQ[$];

  timer_counter #(.PRESET_RESET(32'h0000_0000)) dut (
    .clk    (clk),
    .reset  (reset),
    .Addr   (Addr),
    .WE     (WE),
    .DataIn (DataIn),
    .DataOut(DataOut),
    .IRQ    (IRQ)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One bus write, taking effect at the next rising edge.
  task automatic applyStimulus(input logic [1:0] r, input logic [31:0] d);
    Addr   = {28'd0, r, 2'b00};
    DataIn = d;
    WE     = 1'b1;
    tick();
    WE     = 1'b0;
  endtask

  task automatic checkOutput();
    string       t;
    logic [31:0] e;
    logic        ei;
    t  = tagQ.pop_front();
    e  = dataQ.pop_front();
    ei = irqQ.pop_front();
    checks++;
    assert (DataOut === e) else begin
      errors++;
      $error("[TB] FAIL %s: DataOut=0x%08h expected 0x%08h", t, DataOut, e);
    end
    checks++;
    assert (IRQ === ei) else begin
      errors++;
      $error("[TB] FAIL %s irq: IRQ=%b expected %b", t, IRQ, ei);
    end
  endtask

  task automatic expectRead(input string tag, input logic [1:0] r,
                            input logic [31:0] e, input logic ei);
    tagQ.push_back(tag);
    dataQ.push_back(e);
    irqQ.push_back(ei);
    Addr = {28'd0, r, 2'b00};
    WE   = 1'b0;
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    WE     = 1'b0;
    Addr   = 32'd0;
    DataIn = 32'd0;
    tick();
    tick();
    reset = 1'b0;

    expectRead("rst ctrl",   CTRL,   32'd0, 1'b0);
    expectRead("rst preset", PRESET, 32'd0, 1'b0);
    expectRead("rst count",  COUNT,  32'd0, 1'b0);
    expectRead("rst r3",     R3,     32'd0, 1'b0);

    // One-shot, IM=1, PRESET=5: COUNT 5..0 from e2, IRQ from e7, Enable clears at e8.
    applyStimulus(PRESET, 32'd5);
    applyStimulus(CTRL, 32'h9);
    expectRead("os ctrl e0", CTRL, 32'h9, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      logic [31:0] ec;
      ec = (k >= 2 && k <= 7) ? 32'(7 - k) : 32'd0;
      tick();
      expectRead("os count", COUNT, ec, k >= 7);
      expectRead("os ctrl", CTRL, (k <= 7) ? 32'h9 : 32'h8, k >= 7);
    end
    applyStimulus(CTRL, 32'h8);
    expectRead("os clear", CTRL, 32'h8, 1'b0);

    // Auto-reload, PRESET=3: sequence 3,2,1,0,0 with IRQ on the 0 in INT.
    doReset();
    applyStimulus(PRESET, 32'd3);
    applyStimulus(CTRL, 32'hB);
    for (int k = 1; k <= 12; k++) begin
      int          ph;
      logic [31:0] ec;
      ph = (k - 2) % 5;
      ec = (k >= 2 && ph < 3) ? 32'(3 - ph) : 32'd0;
      tick();
      expectRead("ar count", COUNT, ec, k >= 2 && ph == 3);
    end
    // New PRESET mid-count only affects the next reload.
    applyStimulus(PRESET, 32'd7);
    expectRead("ar pw e13", COUNT, 32'd2, 1'b0);
    tick();
    expectRead("ar pw e14", COUNT, 32'd1, 1'b0);
    tick();
    expectRead("ar pw e15", COUNT, 32'd0, 1'b1);
    tick();
    expectRead("ar pw e16", COUNT, 32'd0, 1'b0);
    tick();
    expectRead("ar pw e17", COUNT, 32'd7, 1'b0);

    // Disable mid-count, ignored writes, then restart from LOAD.
    doReset();
    applyStimulus(PRESET, 32'd4);
    applyStimulus(CTRL, 32'h1);
    tick();
    tick();
    expectRead("dis e2", COUNT, 32'd4, 1'b0);
    tick();
    expectRead("dis e3", COUNT, 32'd3, 1'b0);
    applyStimulus(CTRL, 32'h0);
    expectRead("dis wr", COUNT, 32'd2, 1'b0);
    tick();
    expectRead("dis hold1", COUNT, 32'd2, 1'b0);
    applyStimulus(COUNT, 32'hFFFF_FFFF);
    expectRead("ro count", COUNT, 32'd2, 1'b0);
    applyStimulus(R3, 32'hFFFF_FFFF);
    expectRead("ro r3", R3, 32'd0, 1'b0);
    expectRead("ro preset", PRESET, 32'd4, 1'b0);
    expectRead("ro ctrl", CTRL, 32'd0, 1'b0);
    applyStimulus(CTRL, 32'h1);
    tick();
    expectRead("re e1", COUNT, 32'd2, 1'b0);
    tick();
    expectRead("re e2", COUNT, 32'd4, 1'b0);

    // IM=0 expiry stays silent; a later CTRL write with IM=1 clears the pending flag.
    doReset();
    applyStimulus(PRESET, 32'd2);
    applyStimulus(CTRL, 32'h1);
    for (int k = 1; k <= 5; k++) tick();
    expectRead("im0 ctrl", CTRL, 32'h0, 1'b0);
    expectRead("im0 count", COUNT, 32'd0, 1'b0);
    applyStimulus(CTRL, 32'h8);
    expectRead("im0 unmask", CTRL, 32'h8, 1'b0);
    tick();
    expectRead("im0 later", CTRL, 32'h8, 1'b0);

    // PRESET=0 expires on the edge after LOAD.
    doReset();
    applyStimulus(CTRL, 32'h9);
    tick();
    tick();
    expectRead("p0 e2", COUNT, 32'd0, 1'b0);
    tick();
    expectRead("p0 e3", CTRL, 32'h9, 1'b1);

    // Upper CTRL bits ignored; reset mid-count clears everything.
    doReset();
    applyStimulus(PRESET, 32'd6);
    applyStimulus(CTRL, 32'hFFFF_FFFF);
    expectRead("ctrl mask", CTRL, 32'h0000_000F, 1'b0);
    for (int k = 1; k <= 4; k++) tick();
    expectRead("pre rst", COUNT, 32'd4, 1'b0);
    doReset();
    expectRead("mid rst ctrl",   CTRL,   32'd0, 1'b0);
    expectRead("mid rst preset", PRESET, 32'd0, 1'b0);
    expectRead("mid rst count",  COUNT,  32'd0, 1'b0);
    tick();
    expectRead("post rst count", COUNT, 32'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
